// File: rtl/times_five_contained_class_pkg.sv
// Shared types and constants for the times-five streaming block.
package times_five_contained_class_pkg;

  localparam int DATA_W         = 32;
  localparam int STALL_RATE_W   = 3;
  localparam int STARTUP_CYCLES = 2;

  typedef logic [DATA_W-1:0] uint32_t;

  // a*5 mod 2^32 as a shift-and-add; wraps silently, never saturates.
  function automatic uint32_t times_five(input uint32_t a);
    return (a << 2) + a;
  endfunction

endpackage

// File: rtl/times_five_contained_class_if.sv
// Operand (ready/valid) and result (show-ahead FIFO read) bundle.
// Handshake: an operand transfers on a rising edge where valid_in && rdy_out;
// the producer holds valid_in/a_in until then. A result pops on a rising edge
// where rden_in && !empty_out; result_out is the head whenever empty_out is low.
interface times_five_contained_class_if;
  import times_five_contained_class_pkg::*;

  logic    TimesFiveContained_valid_in;
  uint32_t TimesFiveContained_a_in;
  logic    TimesFiveContained_rdy_out;
  logic    TimesFiveContained_empty_out;
  uint32_t TimesFiveContained_result_out;
  logic    TimesFiveContained_rden_in;

  modport master (
    output TimesFiveContained_valid_in,
    output TimesFiveContained_a_in,
    output TimesFiveContained_rden_in,
    input  TimesFiveContained_rdy_out,
    input  TimesFiveContained_empty_out,
    input  TimesFiveContained_result_out
  );

  modport slave (
    input  TimesFiveContained_valid_in,
    input  TimesFiveContained_a_in,
    input  TimesFiveContained_rden_in,
    output TimesFiveContained_rdy_out,
    output TimesFiveContained_empty_out,
    output TimesFiveContained_result_out
  );

endinterface

// File: rtl/times_five_worker.sv
// Contained worker: two-stage registered multiply-by-five pipeline.
// It never stalls; the parent guarantees a free FIFO slot for every result.
module times_five_worker
  import times_five_contained_class_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  uint32_t in_a,
  output logic    out_valid,
  output uint32_t out_data
);

  logic    s1_valid_q, s1_valid_d;
  uint32_t s1_a_q, s1_a_d;
  logic    s2_valid_q, s2_valid_d;
  uint32_t s2_sum_q, s2_sum_d;

  // Stage 1 captures the operand, stage 2 captures the product.
  always_comb begin
    s1_valid_d = in_valid;
    s1_a_d     = in_valid ? in_a : s1_a_q;
    s2_valid_d = s1_valid_q;
    s2_sum_d   = s1_valid_q ? times_five(s1_a_q) : s2_sum_q;
  end

  // Pipeline registers; valids clear on reset so nothing in flight survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_sum_q;

endmodule

// File: rtl/times_five_contained_class.sv
// Outer wrapper: startup counter, credit tracking and a show-ahead result FIFO
// around the contained times-five worker.
module times_five_contained_class
  import times_five_contained_class_pkg::*;
#(
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    rst_and_startup_done_out,
  times_five_contained_class_if.slave tf,
  output logic                    stall_rate_supported_out,
  input  logic                    stall_rate_valid_in,
  input  logic [STALL_RATE_W-1:0] stall_rate_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]       init_cnt_q, init_cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  uint32_t          head_q, head_d;
  logic             head_valid_q, head_valid_d;
  uint32_t          mem_q [FIFO_DEPTH];

  logic    rdy, accept, pop, load;
  logic    wk_valid;
  uint32_t wk_data;

  // Stall injection is not offered; its inputs are intentionally dropped.
  logic unused_stall;
  assign unused_stall = ^{stall_rate_valid_in, stall_rate_in};
  assign stall_rate_supported_out = 1'b0;

  // Occupancy counts buffered plus in-flight results, so accepting only while
  // it is below depth reserves a FIFO slot for every operand at acceptance.
  assign rdy    = done_q && (occ_q < CNT_W'(FIFO_DEPTH));
  assign accept = tf.TimesFiveContained_valid_in && rdy;
  assign pop    = tf.TimesFiveContained_rden_in && head_valid_q;
  // The head register refills from memory when empty or being popped.
  assign load   = (!head_valid_q || pop) && (mem_cnt_q != '0);

  times_five_worker u_worker (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_a      (tf.TimesFiveContained_a_in),
    .out_valid (wk_valid),
    .out_data  (wk_data)
  );

  // Next-state for startup, credits, pointers and the show-ahead head.
  always_comb begin
    init_cnt_d   = init_cnt_q;
    done_d       = done_q;
    if (!done_q) begin
      init_cnt_d = init_cnt_q + 2'd1;
      done_d     = (init_cnt_d == 2'(STARTUP_CYCLES));
    end
    occ_d        = occ_q + CNT_W'(accept) - CNT_W'(pop);
    wr_ptr_d     = wk_valid ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    mem_cnt_d    = mem_cnt_q + CNT_W'(wk_valid) - CNT_W'(load);
    head_d       = load ? mem_q[rd_ptr_q] : head_q;
    head_valid_d = head_valid_q;
    if (load) begin
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  // Control state; reset discards everything buffered or in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt_q   <= '0;
      done_q       <= 1'b0;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      init_cnt_q   <= init_cnt_d;
      done_q       <= done_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Result storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wk_valid) begin
      mem_q[wr_ptr_q] <= wk_data;
    end
  end

  assign rst_and_startup_done_out      = done_q;
  assign tf.TimesFiveContained_rdy_out    = rdy;
  assign tf.TimesFiveContained_empty_out  = !head_valid_q;
  assign tf.TimesFiveContained_result_out = head_q;

endmodule

// File: tb/tb_times_five_contained_class.sv
// Bench for times_five_contained_class: queue-based reference model with
// cycle-accurate availability, randomized consumer backpressure.
module tb_times_five_contained_class;
  import times_five_contained_class_pkg::*;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       done_out;
  logic       stall_sup;
  logic       stall_v;
  logic [2:0] stall_rate;

  times_five_contained_class_if tf_if ();

  times_five_contained_class #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .rst_and_startup_done_out (done_out),
    .tf                       (tf_if),
    .stall_rate_supported_out (stall_sup),
    .stall_rate_valid_in      (stall_v),
    .stall_rate_in            (stall_rate)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [31:0] exp_q[$];
  int          ready_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          since_rst = 0;
  int          n_acc    = 0;
  int          n_pop    = 0;
  logic        last_acc;
  logic        last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_times_five(input logic [31:0] a);
    logic [63:0] p;
    p = 64'(a) * 64'd5;
    return p[31:0];
  endfunction

  // One clock cycle, entered and left just after a falling edge. Outputs are
  // compared against the model, then inputs are applied for the next edge.
  // A result accepted at edge N is visible after edge N+3; occupancy is the
  // number of accepted-but-unpopped results; startup takes two edges.
  task automatic step(input logic v, input logic [31:0] a, input logic rd);
    logic exp_empty;
    logic exp_rdy;
    logic exp_done;
    exp_done  = (since_rst >= 2);
    exp_empty = (exp_q.size() == 0) || (ready_q[0] > cyc);
    exp_rdy   = exp_done && (exp_q.size() < DEPTH);
    check("done", done_out, exp_done);
    check("rdy", tf_if.TimesFiveContained_rdy_out, exp_rdy);
    check("empty", tf_if.TimesFiveContained_empty_out, exp_empty);
    if (!exp_empty) check("head", tf_if.TimesFiveContained_result_out, exp_q[0]);
    tf_if.TimesFiveContained_valid_in = v;
    tf_if.TimesFiveContained_a_in     = a;
    tf_if.TimesFiveContained_rden_in  = rd;
    last_acc = v && tf_if.TimesFiveContained_rdy_out;
    last_pop = rd && !tf_if.TimesFiveContained_empty_out;
    if (last_pop && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(ready_q.pop_front());
      n_pop++;
    end
    if (last_acc) begin
      exp_q.push_back(ref_times_five(a));
      ready_q.push_back(cyc + 4);
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    since_rst++;
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must return to reset values at once.
  task automatic do_reset();
    tf_if.TimesFiveContained_valid_in = 1'b0;
    tf_if.TimesFiveContained_a_in     = '0;
    tf_if.TimesFiveContained_rden_in  = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_rdy", tf_if.TimesFiveContained_rdy_out, 0);
    check("rst_empty", tf_if.TimesFiveContained_empty_out, 1);
    check("rst_result", tf_if.TimesFiveContained_result_out, 0);
    check("rst_done", done_out, 0);
    check("rst_stall_sup", stall_sup, 0);
    exp_q.delete();
    ready_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_empty", tf_if.TimesFiveContained_empty_out, 1);
    rst = 1'b0;
    since_rst = 0;
  endtask

  initial begin
    int idx;
    int acc0;
    int pop0;
    int budget;
    int phase_left;
    logic rd_state;

    stall_v    = 1'($urandom_range(0, 1));
    stall_rate = 3'($urandom_range(0, 7));
    do_reset();
    repeat (4) step(1'b0, '0, 1'b0);

    // Basic: 0..9 with an always-reading consumer
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);

    // Wraparound operands
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 32'h3333_3334, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);

    // Fill: offer 40, never read, then drain
    idx  = 0;
    acc0 = n_acc;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'(idx), 1'b0);
      if (last_acc) idx++;
    end
    repeat (4) step(1'b0, '0, 1'b0);
    check("fill_accepted", 32'(n_acc - acc0), 32);
    pop0 = n_pop;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) step(1'b0, '0, 1'b1);
    check("fill_drained", 32'(n_pop - pop0), 32);

    // Backpressure: 32768 operands, consumer reads in random bursts
    idx        = 0;
    budget     = 0;
    phase_left = 0;
    rd_state   = 1'b0;
    while ((idx < 32768 || exp_q.size() > 0) && budget < 90000) begin
      if (phase_left == 0) begin
        rd_state   = !rd_state;
        phase_left = rd_state ? $urandom_range(1, 64) : $urandom_range(1, 16);
      end
      phase_left--;
      step(idx < 32768, 32'(idx), rd_state);
      if (last_acc) idx++;
      budget++;
    end
    check("bp_in_budget", 32'(budget < 90000), 1);
    check("bp_accepted", 32'(idx), 32768);

    // Empty read is harmless, then operand 7
    repeat (5) step(1'b0, '0, 1'b1);
    step(1'b1, 32'd7, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);

    // Reset with 10 results buffered
    for (int i = 0; i < 10; i++) step(1'b1, 32'(100 + i), 1'b0);
    repeat (4) step(1'b0, '0, 1'b0);
    do_reset();
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b1, 32'd3, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);
    check("final_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
